fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for `mycpu`. It owns the program counter and drives the memory read handshake. It pulses the instruction-load strobe of the `ir` instruction register so that `ir` captures each fetched word. It then holds until the execute stage signals completion, and advances or jumps the program counter.

## Interface
Parameters:
- `RESET_PC`, `16'h0000`: program counter value after reset and after each `start_in`.
- `PC_STEP`, `16'h0001`: increment applied to the PC after each fetched instruction.
- `TIMEOUT`, `8`: maximum number of FETCH cycles without `mem_ack_in`. Used only when `FETCH_TIMEOUT_EN` is defined. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_in`  in  1  one-cycle pulse; loads `RESET_PC` and begins fetching. Accepted only in IDLE or ERROR.
- `halt_in`  in  1  level; sampled on `next_in`. If high, the block returns to IDLE instead of fetching again.
- `mem_ack_in`  in  1  memory read data valid on the instruction bus this cycle.
- `next_in`  in  1  one-cycle pulse from the execute stage: current instruction finished.
- `jump_in`  in  1  qualifies `next_in`; take a jump.
- `ja_in`  in  16  jump target address, sampled with `next_in && jump_in`.
- `mem_req_out`  out  1  memory read request.
- `mem_addr_out`  out  16  read address; always equals `pc_out`.
- `il_out`  out  1  instruction-load strobe to `ir.il_in`.
- `pc_out`  out  16  current program counter.
- `busy_out`  out  1  high in FETCH and EXEC.
- `err_out`  out  1  memory timeout flag; sticky.

## Operation
- States:
  - IDLE (reset state)
  - FETCH
  - EXEC
  - ERROR (only when `FETCH_TIMEOUT_EN` is defined)
- IDLE: all strobes low. On `start_in`: `pc <= RESET_PC`, clear `err_out`, go to FETCH.
- FETCH:
  - `mem_req_out=1`.
  - `il_out = mem_ack_in`, combinational, so `ir` captures `ins_in` on the same edge.
  - On `mem_ack_in`: `pc <= pc + PC_STEP` (mod 2^16; `16'hFFFF+1 = 16'h0000`), go to EXEC.
  - `halt_in`, `next_in` and `start_in` are ignored in FETCH.
- EXEC: `mem_req_out=0`, `il_out=0`. On `next_in`:
  - If `jump_in`, then `pc <= ja_in`; otherwise PC is unchanged.
  - If `halt_in`, go to IDLE; otherwise go to FETCH.
  - The jump and the halt both apply when they occur together, so PC holds `ja_in` in IDLE.
- `mem_ack_in` outside FETCH is ignored; `il_out` stays low.
- `jump_in` without `next_in` is ignored.
- ERROR: see Configuration. `busy_out=0`. `start_in` restarts exactly as from IDLE.
- Reset asserted in any state, including mid-handshake: immediate return to IDLE, all outputs at reset values, any timeout count discarded.

## Timing
- Reset values:
  - `mem_req_out=0`, `il_out=0`, `busy_out=0`, `err_out=0`.
  - `pc_out=RESET_PC`, `mem_addr_out=RESET_PC`.
- `start_in` high in cycle n: `mem_req_out` and `busy_out` are high from cycle n+1.
- Zero-wait memory: `mem_ack_in` high in the first FETCH cycle gives a 1-cycle fetch. `il_out` is high in that cycle, and EXEC begins the next cycle.
- Back-to-back minimum: two cycles per instruction (FETCH with immediate ack, EXEC with immediate `next_in`).
- `pc_out` updates on the edge that leaves FETCH, so in EXEC it already points to the next sequential address.
- `mem_req_out` stays high until the ack cycle, inclusive; it drops on the following edge.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on FETCH entry and increments each FETCH cycle without `mem_ack_in`.
  - When the counter reaches `TIMEOUT` without an ack, the next state is ERROR: `err_out` is set and `mem_req_out` drops.
  - An ack in the cycle where the count equals `TIMEOUT - 1` is still accepted normally.
- `FETCH_TIMEOUT_EN` not defined: no counter and no ERROR state; FETCH waits indefinitely; `err_out` is tied to 0.

## Test plan
- Reset, then `start_in`, then ack in the first FETCH cycle: `mem_addr_out=16'h0000`, one-cycle `il_out` pulse coincident with the ack, then EXEC with `pc_out=16'h0001`.
- Ack delayed by 3 cycles: `mem_req_out` high for 4 cycles, a single `il_out` pulse on the 4th, and `pc_out` increments exactly once.
- EXEC with `next_in=1`, `jump_in=1`, `ja_in=16'h1234`: the next FETCH has `mem_addr_out=16'h1234`. A further `next_in` with `halt_in=1` gives IDLE and `busy_out=0`.
- PC wrap: jump to `16'hFFFF`, then fetch with ack: `pc_out=16'h0000` in EXEC.
- With `FETCH_TIMEOUT_EN` defined and `TIMEOUT=8`:
  - No ack: ERROR after 8 FETCH cycles, `err_out=1`, `mem_req_out=0`.
  - `start_in` then clears `err_out` and refetches from `RESET_PC`.
  - An ack on FETCH cycle 8 is accepted normally.
- `rst_n` asserted while `mem_req_out=1`: outputs reach reset values without waiting for a clock edge, and a later ack is ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the memory read handshake, strobes ir.il_in.
// Latency: 1 cycle from start_in to mem_req_out; 1-cycle fetch on a zero-wait ack; 2 cycles/instr minimum.
// Backpressure: FETCH holds mem_req_out until mem_ack_in; EXEC holds until next_in.
// Optional feature macro: FETCH_TIMEOUT_EN (fetch wait counter, ERROR state, sticky err_out).
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0001,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic        halt_in,
  input  logic        mem_ack_in,
  input  logic        next_in,
  input  logic        jump_in,
  input  logic [15:0] ja_in,
  output logic        mem_req_out,
  output logic [15:0] mem_addr_out,
  output logic        il_out,
  output logic [15:0] pc_out,
  output logic        busy_out,
  output logic        err_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
`ifdef FETCH_TIMEOUT_EN
    , ST_ERROR = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;

`ifdef FETCH_TIMEOUT_EN
  // Last count at which an ack is still accepted; one more empty cycle times out.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // State, PC and (optional) timeout registers; reset drops everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state, PC update and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_out = 1'b0;
    il_out      = 1'b0;
    busy_out    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          pc_d    = RESET_PC;
          state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
          err_d   = 1'b0;
          cnt_d   = 8'd0;
`endif
        end
      end

      ST_FETCH: begin
        mem_req_out = 1'b1;
        busy_out    = 1'b1;
        // ir captures the bus word on the same edge that the ack is seen.
        il_out      = mem_ack_in;
        if (mem_ack_in) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      ST_EXEC: begin
        busy_out = 1'b1;
        if (next_in) begin
          // Jump and halt compose: a halting jump parks the target in the PC.
          if (jump_in) begin
            pc_d = ja_in;
          end
          if (halt_in) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end
      end

`ifdef FETCH_TIMEOUT_EN
      ST_ERROR: begin
        // Restart behaves exactly like a start from IDLE; err_out clears here.
        if (start_in) begin
          pc_d    = RESET_PC;
          state_d = ST_FETCH;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The read address is the PC by construction.
  assign mem_addr_out = pc_q;
  assign pc_out       = pc_q;

`ifdef FETCH_TIMEOUT_EN
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_in, halt_in, mem_ack_in, next_in, jump_in;
  logic [15:0] ja_in;
  logic        mem_req_out, il_out, busy_out, err_out;
  logic [15:0] mem_addr_out, pc_out;

  int n_cmp;
  int n_err;

  fetch_ctrl #(
    .RESET_PC (16'h0000),
    .PC_STEP  (16'h0001),
    .TIMEOUT  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_in     (start_in),
    .halt_in      (halt_in),
    .mem_ack_in   (mem_ack_in),
    .next_in      (next_in),
    .jump_in      (jump_in),
    .ja_in        (ja_in),
    .mem_req_out  (mem_req_out),
    .mem_addr_out (mem_addr_out),
    .il_out       (il_out),
    .pc_out       (pc_out),
    .busy_out     (busy_out),
    .err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start, halt, ack, nxt, jump;
    logic [15:0] ja;
    logic        req, il, busy;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic req, input logic il,
                            input logic busy, input logic err, input logic [15:0] pc);
    check({tag, ".mem_req"}, {15'd0, mem_req_out}, {15'd0, req});
    check({tag, ".il"},      {15'd0, il_out},      {15'd0, il});
    check({tag, ".busy"},    {15'd0, busy_out},    {15'd0, busy});
    check({tag, ".err"},     {15'd0, err_out},     {15'd0, err});
    check({tag, ".pc"},      pc_out,               pc);
    check({tag, ".addr"},    mem_addr_out,         pc);
  endtask

  // Apply inputs on the falling edge; they are sampled on the following rising edge.
  task automatic cyc(input logic s, input logic h, input logic a, input logic n,
                     input logic j, input logic [15:0] ja);
    @(negedge clk);
    start_in = s; halt_in = h; mem_ack_in = a; next_in = n; jump_in = j; ja_in = ja;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    // fields: start halt ack next jump ja | req il busy pc
    tbl[0]  = '{0,0,0,0,0,16'h0000, 0,0,0,16'h0000};
    tbl[1]  = '{1,0,0,0,0,16'h0000, 0,0,0,16'h0000};
    tbl[2]  = '{0,0,1,0,0,16'h0000, 1,1,1,16'h0000};
    tbl[3]  = '{0,0,0,0,0,16'h0000, 0,0,1,16'h0001};
    tbl[4]  = '{0,0,0,0,1,16'h5555, 0,0,1,16'h0001};
    tbl[5]  = '{0,0,1,0,0,16'h0000, 0,0,1,16'h0001};
    tbl[6]  = '{0,0,0,1,0,16'h0000, 0,0,1,16'h0001};
    tbl[7]  = '{0,0,0,0,0,16'h0000, 1,0,1,16'h0001};
    tbl[8]  = '{1,1,0,1,1,16'h7777, 1,0,1,16'h0001};
    tbl[9]  = '{0,0,0,0,0,16'h0000, 1,0,1,16'h0001};
    tbl[10] = '{0,0,1,0,0,16'h0000, 1,1,1,16'h0001};
    tbl[11] = '{0,0,0,0,0,16'h0000, 0,0,1,16'h0002};
    tbl[12] = '{0,0,0,1,1,16'h1234, 0,0,1,16'h0002};
    tbl[13] = '{0,0,1,0,0,16'h0000, 1,1,1,16'h1234};
    tbl[14] = '{0,1,0,1,0,16'h0000, 0,0,1,16'h1235};
    tbl[15] = '{0,0,0,0,0,16'h0000, 0,0,0,16'h1235};
    tbl[16] = '{0,0,1,1,1,16'h4444, 0,0,0,16'h1235};
    tbl[17] = '{1,0,0,0,0,16'h0000, 0,0,0,16'h1235};
    tbl[18] = '{0,0,1,0,0,16'h0000, 1,1,1,16'h0000};
    tbl[19] = '{0,0,0,1,1,16'hFFFF, 0,0,1,16'h0001};
    tbl[20] = '{0,0,1,0,0,16'h0000, 1,1,1,16'hFFFF};
    tbl[21] = '{0,1,0,1,1,16'h00AB, 0,0,1,16'h0000};
    tbl[22] = '{0,0,0,0,0,16'h0000, 0,0,0,16'h00AB};

    start_in = 0; halt_in = 0; mem_ack_in = 0; next_in = 0; jump_in = 0; ja_in = 16'h0;
    rst_n = 1'b0;
    #1;
    check_outs("reset", 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].start, tbl[i].halt, tbl[i].ack, tbl[i].nxt, tbl[i].jump, tbl[i].ja);
      check_outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].il, tbl[i].busy, 1'b0, tbl[i].pc);
    end

    // Asynchronous reset in the middle of a pending fetch.
    cyc(1,0,0,0,0,16'h0);
    cyc(0,0,1,0,0,16'h0);
    cyc(0,0,0,1,0,16'h0);
    cyc(0,0,0,0,0,16'h0);
    check_outs("pre_rst", 1, 0, 1, 0, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 16'h0000);
    mem_ack_in = 1'b1;
    #1;
    check_outs("rst_ack", 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cyc(0,0,1,0,0,16'h0);
    check_outs("post_rst_ack", 0, 0, 0, 0, 16'h0000);
    cyc(0,0,0,0,0,16'h0);
    check_outs("post_rst_idle", 0, 0, 0, 0, 16'h0000);

`ifdef FETCH_TIMEOUT_EN
    // No ack: eight FETCH cycles with the request up, then ERROR.
    cyc(0,0,0,1,1,16'h0042);
    cyc(0,1,0,1,1,16'h0042);
    cyc(1,0,0,0,0,16'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0,0,0,0,0,16'h0);
      check_outs($sformatf("to_fetch%0d", k), 1, 0, 1, 0, 16'h0000);
    end
    cyc(0,0,1,0,0,16'h0);
    check_outs("to_error", 0, 0, 0, 1, 16'h0000);
    cyc(0,0,0,0,0,16'h0);
    check_outs("to_sticky", 0, 0, 0, 1, 16'h0000);
    // Restart from ERROR; ack arrives on the eighth FETCH cycle.
    cyc(1,0,0,0,0,16'h0);
    check_outs("to_restart", 0, 0, 0, 1, 16'h0000);
    for (int k = 1; k <= 7; k++) begin
      cyc(0,0,0,0,0,16'h0);
      check_outs($sformatf("re_fetch%0d", k), 1, 0, 1, 0, 16'h0000);
    end
    cyc(0,0,1,0,0,16'h0);
    check_outs("late_ack", 1, 1, 1, 0, 16'h0000);
    cyc(0,0,0,0,0,16'h0);
    check_outs("late_exec", 0, 0, 1, 0, 16'h0001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
